mc_control_fsm: RTL
===================

# mc_control_fsm

Main control state machine for the multicycle MIPS core. It sits directly upstream of the datapath:
- decodes the instruction register's opcode and funct fields;
- steps through the fetch/decode/execute/memory/writeback states;
- drives every datapath mux select and write enable, including the 3-bit ALU control.

It is a Moore machine with a small combinational ALU decoder.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26], driven from the datapath instruction register
- funct  in  6  instr[5:0], driven from the datapath instruction register
- mem_to_reg  out  1  register write data select: 1 = memory data register, 0 = ALU out
- reg_dest  out  1  destination register select: 1 = rd, 0 = rt
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU out
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALU out, 10 = jump target
- alu_control  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- ir_write  out  1  instruction register load enable
- mem_write  out  1  memory write enable
- pc_write  out  1  unconditional PC write
- branch  out  1  conditional PC write when the ALU zero flag is 1
- branch_ne  out  1  conditional PC write when the ALU zero flag is 0
- reg_write  out  1  register file write enable
- illegal_op  out  1  unrecognised opcode flag; asserted in DECODE
- state  out  4  current state encoding, for debug

## Operation
State encodings, listed with the outputs each state asserts (every unlisted output is 0; alu_op is internal):
- FETCH = 0: ir_write=1, pc_write=1, alu_src_b=01, alu_op=00
- DECODE = 1: alu_src_b=11, alu_op=00
- MEMADR = 2: alu_src_a=1, alu_src_b=10
- MEMREAD = 3: i_or_d=1
- MEMWB = 4: mem_to_reg=1, reg_write=1
- MEMWRITE = 5: i_or_d=1, mem_write=1
- EXECUTE = 6: alu_src_a=1, alu_op=10
- ALUWB = 7: reg_dest=1, reg_write=1
- BRANCH = 8: alu_src_a=1, alu_op=01, pc_src=01, branch=1
- ADDIEXEC = 9: alu_src_a=1, alu_src_b=10
- ADDIWB = 10: reg_write=1
- JUMP = 11: pc_src=10, pc_write=1
- BNE = 12: same outputs as BRANCH, except branch=0 and branch_ne=1

Transitions:
- FETCH→DECODE.
- DECODE→ next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEXEC
  - 000010 (j) → JUMP
  - 000101 (bne) → BNE; only when the macro in Configuration is defined
  - any other opcode → FETCH, with illegal_op=1 for that DECODE cycle
- MEMADR→MEMREAD if opcode is lw, else MEMWRITE.
- MEMREAD→MEMWB.
- EXECUTE→ALUWB.
- ADDIEXEC→ADDIWB.
- Return to FETCH from MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH, BNE and JUMP.
- State codes 13–15 are unreachable; if entered, the next state is FETCH and outputs take FETCH values.

ALU decoder (combinational):
- alu_op 00 → 010 (add).
- alu_op 01 → 110 (sub).
- alu_op 10 decodes funct:
  - 100000 → 010 (add)
  - 100010 → 110 (sub)
  - 100100 → 000 (and)
  - 100101 → 001 (or)
  - 101010 → 111 (slt)
  - any other funct → 010; no exception is raised.

## Timing
- Reset is asynchronous: state goes to FETCH immediately when rst_n falls.
- While rst_n is low, ir_write, pc_write, mem_write, reg_write, branch, branch_ne and illegal_op are forced to 0 combinationally. Mux selects show FETCH values: alu_src_b=01, alu_control=010, all other selects 0.
- On the first rising edge after rst_n rises, the FSM performs FETCH. Release is taken synchronous to clk.
- Reset asserted mid-instruction aborts it. No write enable is asserted once rst_n is low.
- All outputs are pure functions of state, plus opcode for illegal_op and funct for alu_control. There are no registered outputs and zero input-to-output latency.
- opcode and funct must be stable from the end of FETCH until the instruction returns to FETCH. The datapath guarantees this because ir_write is asserted only in FETCH.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, bne 3, j 3, illegal opcode 2.

## Configuration
- MC_CTRL_BNE_EN defined:
  - opcode 000101 is decoded and the BNE state (12) is reachable;
  - branch_ne is driven as specified above.
- MC_CTRL_BNE_EN undefined:
  - opcode 000101 is treated as illegal: DECODE→FETCH with illegal_op=1;
  - state 12 does not exist and branch_ne is tied to 0.

## Test plan
- Hold rst_n=0 for 3 cycles with clk running → state=0 and all write enables 0 throughout. Release → pc_write=1 and ir_write=1 in the first cycle.
- lw (opcode 100011) → state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in cycle 5. i_or_d=1 only in cycle 4.
- R-type with each funct in turn (100000, 100010, 100100, 100101, 101010) → alu_control 010, 110, 000, 001, 111 in EXECUTE. ALUWB has reg_dest=1, reg_write=1. Total of 4 cycles.
- beq, then j → beq gives 0,1,8,0 with branch=1, pc_src=01, alu_control=110 in state 8. j gives 0,1,11,0 with pc_write=1, pc_src=10.
- opcode 111111, then 000101 with MC_CTRL_BNE_EN undefined → each gives 0,1,0 with illegal_op=1 in DECODE. With the macro defined, 000101 gives 0,1,12,0 with branch_ne=1 and branch=0.
- Pull rst_n low asynchronously in MEMWRITE (state 5) → mem_write falls in the same cycle and state=0 without waiting for a clock edge.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Main control state machine for the multicycle MIPS core. A Moore machine
// that steps each instruction through fetch/decode/execute/memory/writeback
// and drives every datapath mux select and write enable. A small
// combinational ALU decoder produces the 3-bit ALU control.
//
// Ports:
//   clk, rst_n         core clock, asynchronous active-low reset
//   opcode, funct      instruction fields from the instruction register
//   mem_to_reg, reg_dest, i_or_d, alu_src_a, alu_src_b, pc_src
//                      datapath mux selects
//   alu_control        ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   ir_write, mem_write, pc_write, branch, branch_ne, reg_write
//                      write enables; all held at 0 while rst_n is low
//   illegal_op         unrecognised opcode flag, valid in DECODE
//   state              current state encoding, for debug
//
// Optional feature: define MC_CTRL_BNE_EN to decode bne (opcode 000101) and
// enable the BNE state. Without it, bne is an illegal opcode and branch_ne
// is tied to 0.

module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       mem_to_reg,
    output logic       reg_dest,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       ir_write,
    output logic       mem_write,
    output logic       pc_write,
    output logic       branch,
    output logic       branch_ne,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
`ifdef MC_CTRL_BNE_EN
        S_JUMP     = 4'd11,
        S_BNE      = 4'd12
`else
        S_JUMP     = 4'd11
`endif
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] aluOp;
    logic       irWriteRaw, memWriteRaw, pcWriteRaw, branchRaw, regWriteRaw;
    logic       illegalRaw;
`ifdef MC_CTRL_BNE_EN
    logic       branchNeRaw;
`endif

    // State register; reset lands in FETCH without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Any code without an explicit arc (including the
    // unused encodings) falls back to FETCH.
    always_comb begin
        state_d    = S_FETCH;
        illegalRaw = 1'b0;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default: begin
                        state_d    = S_FETCH;
                        illegalRaw = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore outputs per state. Unused encodings reproduce FETCH outputs.
    always_comb begin
        mem_to_reg  = 1'b0;
        reg_dest    = 1'b0;
        i_or_d      = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        aluOp       = 2'b00;
        irWriteRaw  = 1'b0;
        memWriteRaw = 1'b0;
        pcWriteRaw  = 1'b0;
        branchRaw   = 1'b0;
        regWriteRaw = 1'b0;
`ifdef MC_CTRL_BNE_EN
        branchNeRaw = 1'b0;
`endif
        case (state_q)
            S_DECODE:   alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD:  i_or_d = 1'b1;
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                regWriteRaw = 1'b1;
            end
            S_MEMWRITE: begin
                i_or_d      = 1'b1;
                memWriteRaw = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                aluOp     = 2'b10;
            end
            S_ALUWB: begin
                reg_dest    = 1'b1;
                regWriteRaw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluOp     = 2'b01;
                pc_src    = 2'b01;
                branchRaw = 1'b1;
            end
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB:   regWriteRaw = 1'b1;
            S_JUMP: begin
                pc_src     = 2'b10;
                pcWriteRaw = 1'b1;
            end
`ifdef MC_CTRL_BNE_EN
            S_BNE: begin
                alu_src_a   = 1'b1;
                aluOp       = 2'b01;
                pc_src      = 2'b01;
                branchNeRaw = 1'b1;
            end
`endif
            default: begin
                irWriteRaw = 1'b1;
                pcWriteRaw = 1'b1;
                alu_src_b  = 2'b01;
            end
        endcase
    end

    // ALU decoder; unknown funct codes quietly fall back to add.
    always_comb begin
        alu_control = 3'b010;
        case (aluOp)
            2'b01: alu_control = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
            default: alu_control = 3'b010;
        endcase
    end

    // Write enables are masked by rst_n so an abort never leaves a write
    // pending, even in the cycle reset is asserted.
    assign ir_write   = irWriteRaw  & rst_n;
    assign mem_write  = memWriteRaw & rst_n;
    assign pc_write   = pcWriteRaw  & rst_n;
    assign branch     = branchRaw   & rst_n;
    assign reg_write  = regWriteRaw & rst_n;
    assign illegal_op = illegalRaw  & rst_n;
`ifdef MC_CTRL_BNE_EN
    assign branch_ne  = branchNeRaw & rst_n;
`else
    assign branch_ne  = 1'b0;
`endif
    assign state      = state_q;

endmodule
